// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the ID/EX operand stage.
//   - AF_*      : ALU function codes carried from decode to the ALU.
//   - REG_ZERO  : index of the hard-wired zero register.
//   - fwd_sel_t : operand source chosen by the forwarding network.
package mips_pkg;

   localparam logic [3:0] AF_ADD = 4'b0000;
   localparam logic [3:0] AF_SUB = 4'b0001;
   localparam logic [3:0] AF_AND = 4'b0010;
   localparam logic [3:0] AF_OR  = 4'b0011;
   localparam logic [3:0] AF_XOR = 4'b0100;
   localparam logic [3:0] AF_SLT = 4'b0101;
   localparam logic [3:0] AF_SLL = 4'b0110;
   localparam logic [3:0] AF_SRL = 4'b0111;
   localparam logic [3:0] AF_LUI = 4'b1000;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
//   Two-way priority forward select for one source operand in EX.
//   A MEM-stage match wins over a WB-stage match; register 0 is never forwarded.
// Ports
//   idx          in  REG_AW  latched source register index
//   reg_val      in  DATA_W  latched operand value
//   mem_reg_write/mem_rd/mem_result  in  MEM-stage write-back candidate
//   wb_reg_write/wb_rd/wb_result     in  WB-stage write-back candidate
//   fwd_val      out DATA_W  operand value after forwarding
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] idx,
   input  logic [DATA_W-1:0] reg_val,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] fwd_val
);

   localparam logic [REG_AW-1:0] RZERO = REG_AW'(REG_ZERO);

   fwd_sel_t sel_s;

   // Choose the youngest in-flight producer of idx.
   always_comb begin
      sel_s = FWD_REG;
      if (mem_reg_write && (mem_rd != RZERO) && (mem_rd == idx)) begin
         sel_s = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != RZERO) && (wb_rd == idx)) begin
         sel_s = FWD_WB;
      end else begin
         sel_s = FWD_REG;
      end
   end

   // Steer the selected source onto the operand.
   always_comb begin
      fwd_val = reg_val;
      case (sel_s)
         FWD_MEM: fwd_val = mem_result;
         FWD_WB:  fwd_val = wb_result;
         default: fwd_val = reg_val;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register plus operand selection feeding the ALU.
//   Captures decoded fields (with WB bypass and immediate extension), forwards
//   from MEM/WB in EX, and detects load-use hazards to insert one bubble.
// Ports
//   clk, rst_n, stall, flush          clock, async reset, freeze, kill
//   id_*                              decoded instruction from ID
//   mem_reg_write/mem_rd/mem_result   MEM-stage producer
//   wb_reg_write/wb_rd/wb_result      WB-stage producer
//   SrcA, SrcB, af, i                 ALU operands and controls (same cycle)
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_store_data   EX status
//   lu_hazard                         hold ID; a bubble enters EX
module id_ex_operand_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [15:0]       id_imm16,
   input  logic              id_imm_sext,
   input  logic              id_i,
   input  logic [3:0]        id_af,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_uses_rt,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] SrcA,
   output logic [DATA_W-1:0] SrcB,
   output logic [3:0]        af,
   output logic              i,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              lu_hazard
);

   localparam logic [REG_AW-1:0] RZERO = REG_AW'(REG_ZERO);

   logic              ex_valid_r;
   logic [REG_AW-1:0] rs_idx_r;
   logic [REG_AW-1:0] rt_idx_r;
   logic [DATA_W-1:0] rs_val_r;
   logic [DATA_W-1:0] rt_val_r;
   logic [DATA_W-1:0] imm_ext_r;
   logic              i_r;
   logic [3:0]        af_r;
   logic [REG_AW-1:0] rd_r;
   logic              reg_write_r;
   logic              mem_read_r;

   logic [DATA_W-1:0] cap_rs_val_s;
   logic [DATA_W-1:0] cap_rt_val_s;
   logic [DATA_W-1:0] imm_ext_s;
   logic [DATA_W-1:0] fwd_rs_s;
   logic [DATA_W-1:0] fwd_rt_s;
   logic              lu_hazard_s;

   // WB writes the register file in the same cycle ID reads it, so the read
   // data can be stale; take the WB value at capture time instead.
   always_comb begin
      cap_rs_val_s = id_rs_val;
      cap_rt_val_s = id_rt_val;
      if (wb_reg_write && (wb_rd != RZERO) && (wb_rd == id_rs)) begin
         cap_rs_val_s = wb_result;
      end else begin
         cap_rs_val_s = id_rs_val;
      end
      if (wb_reg_write && (wb_rd != RZERO) && (wb_rd == id_rt)) begin
         cap_rt_val_s = wb_result;
      end else begin
         cap_rt_val_s = id_rt_val;
      end
   end

   // Sign- or zero-extend the 16-bit immediate to the datapath width.
   always_comb begin
      imm_ext_s = {{(DATA_W-16){id_imm16[15] & id_imm_sext}}, id_imm16};
   end

   // A load in EX whose result ID needs cannot be forwarded in time.
   always_comb begin
      lu_hazard_s = ex_valid_r & mem_read_r & (rd_r != RZERO) & id_valid &
                    ((id_rs == rd_r) | (id_uses_rt & (id_rt == rd_r)));
   end

   // ID/EX register: stall holds, flush or load-use loads a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_r  <= 1'b0;
         rs_idx_r    <= '0;
         rt_idx_r    <= '0;
         rs_val_r    <= '0;
         rt_val_r    <= '0;
         imm_ext_r   <= '0;
         i_r         <= 1'b0;
         af_r        <= 4'b0000;
         rd_r        <= '0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
      end else if (!stall) begin
         if (flush || lu_hazard_s) begin
            ex_valid_r  <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
         end else begin
            ex_valid_r  <= id_valid;
            rs_idx_r    <= id_rs;
            rt_idx_r    <= id_rt;
            rs_val_r    <= cap_rs_val_s;
            rt_val_r    <= cap_rt_val_s;
            imm_ext_r   <= imm_ext_s;
            i_r         <= id_i;
            af_r        <= id_af;
            rd_r        <= id_rd;
            reg_write_r <= id_reg_write;
            mem_read_r  <= id_mem_read;
         end
      end
   end

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .idx           (rs_idx_r),
      .reg_val       (rs_val_r),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .fwd_val       (fwd_rs_s)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .idx           (rt_idx_r),
      .reg_val       (rt_val_r),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .fwd_val       (fwd_rt_s)
   );

   // Operands go straight to the ALU; forwarding stays live during a stall.
   always_comb begin
      SrcA          = fwd_rs_s;
      SrcB          = i_r ? imm_ext_r : fwd_rt_s;
      ex_store_data = fwd_rt_s;
   end

   assign af           = af_r;
   assign i            = i_r;
   assign ex_valid     = ex_valid_r;
   assign ex_rd        = rd_r;
   assign ex_reg_write = ex_valid_r & reg_write_r;
   assign ex_mem_read  = ex_valid_r & mem_read_r;
   assign lu_hazard    = lu_hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_val, id_rt_val;
   logic [15:0] id_imm16;
   logic        id_imm_sext, id_i;
   logic [3:0]  id_af;
   logic        id_reg_write, id_mem_read, id_uses_rt;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic [31:0] SrcA, SrcB, ex_store_data;
   logic [3:0]  af;
   logic        i, ex_valid, ex_reg_write, ex_mem_read, lu_hazard;
   logic [4:0]  ex_rd;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic        valid;
      logic        chk_ops;
      logic [31:0] srca;
      logic [31:0] srcb;
      logic [31:0] store;
      logic [3:0]  af;
      logic        i;
   } exp_t;

   exp_t sb[$];

   id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
      .id_imm_sext(id_imm_sext), .id_i(id_i), .id_af(id_af),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_uses_rt(id_uses_rt),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .SrcA(SrcA), .SrcB(SrcB), .af(af), .i(i), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_store_data(ex_store_data), .lu_hazard(lu_hazard)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic [15:0] imm, input logic sext, input logic ii,
                         input logic [3:0] f, input logic rw, input logic mr, input logic ut);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_val = rsv; id_rt_val = rtv; id_imm16 = imm; id_imm_sext = sext;
      id_i = ii; id_af = f; id_reg_write = rw; id_mem_read = mr; id_uses_rt = ut;
   endtask

   task automatic no_fwd();
      mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
      wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;
   endtask

   task automatic push(input string tag, input logic v, input logic ops, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] st, input logic [3:0] f,
                       input logic ii);
      exp_t e;
      e.tag = tag; e.valid = v; e.chk_ops = ops; e.srca = a; e.srcb = b;
      e.store = st; e.af = f; e.i = ii;
      sb.push_back(e);
   endtask

   task automatic check_ex();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_valid"}, 32'(ex_valid), 32'(e.valid));
         if (e.chk_ops) begin
            chk({e.tag, "_srca"}, SrcA, e.srca);
            chk({e.tag, "_srcb"}, SrcB, e.srcb);
            chk({e.tag, "_store"}, ex_store_data, e.store);
            chk({e.tag, "_af"}, 32'(af), 32'(e.af));
            chk({e.tag, "_i"}, 32'(i), 32'(e.i));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b0, 1'b0, 1'b0);
      no_fwd();
      #2;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_srca", SrcA, 32'h0);
      chk("rst_srcb", SrcB, 32'h0);
      chk("rst_lu", 32'(lu_hazard), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // addi r3, r0, 0x55
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 16'h0055, 1'b1, 1'b1, AF_ADD, 1'b1, 1'b0, 1'b0);
      push("addi_r3", 1'b1, 1'b1, 32'h0, 32'h55, 32'h0, AF_ADD, 1'b0 | 1'b1);
      step();
      // add r4, r3, r3 with stale register-file data
      set_id(1'b1, 5'd3, 5'd3, 5'd4, 32'hDEAD, 32'hBEEF, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b1, 1'b0, 1'b1);
      push("mem_fwd", 1'b1, 1'b1, 32'h55, 32'h55, 32'h55, AF_ADD, 1'b0);
      #1;
      check_ex();
      chk("no_lu_alu", 32'(lu_hazard), 32'd0);
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h55;
      // add r7, r5, r0
      set_id(1'b1, 5'd5, 5'd0, 5'd7, 32'h99, 32'h0, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b1, 1'b0, 1'b1);
      push("mem_over_wb", 1'b1, 1'b1, 32'h11, 32'h0, 32'h0, AF_ADD, 1'b0);
      #1;
      check_ex();
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'h11;
      wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'h22;
      stall = 1'b1;
      #1;
      check_ex();
      mem_reg_write = 1'b0;
      #1;
      chk("wb_fwd_srca", SrcA, 32'h22);
      step();
      chk("stall_wb_fwd_srca", SrcA, 32'h22);
      stall = 1'b0;

      // add r8, r9, r9 while WB writes r9 -> bypass at capture
      wb_reg_write = 1'b1; wb_rd = 5'd9; wb_result = 32'h77;
      set_id(1'b1, 5'd9, 5'd9, 5'd8, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b1, 1'b0, 1'b1);
      push("wb_capture", 1'b1, 1'b1, 32'h77, 32'h77, 32'h77, AF_ADD, 1'b0);
      step();
      no_fwd();
      // add r1, r0, r0
      set_id(1'b1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b1, 1'b0, 1'b1);
      push("r0_nofwd", 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, AF_ADD, 1'b0);
      #1;
      check_ex();
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
      wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hEE;
      // addi r1, r2, 0x8000 (sign-extended)
      set_id(1'b1, 5'd2, 5'd0, 5'd1, 32'h10, 32'h0, 16'h8000, 1'b1, 1'b1, AF_ADD, 1'b1, 1'b0, 1'b0);
      #1;
      check_ex();
      no_fwd();
      push("imm_sext", 1'b1, 1'b1, 32'h10, 32'hFFFF8000, 32'h0, AF_ADD, 1'b1);
      step();
      // lui r5, 0x1234 (zero-extended)
      set_id(1'b1, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 16'h1234, 1'b0, 1'b1, AF_LUI, 1'b1, 1'b0, 1'b0);
      push("lui_zext", 1'b1, 1'b1, 32'h0, 32'h00001234, 32'h0, AF_LUI, 1'b1);
      #1;
      check_ex();
      step();
      // sw r4, 8(r1)
      set_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h100, 32'hCAFE, 16'h0008, 1'b1, 1'b1, AF_ADD, 1'b0, 1'b0, 1'b1);
      push("sw_store", 1'b1, 1'b1, 32'h100, 32'h8, 32'hCAFE, AF_ADD, 1'b1);
      #1;
      check_ex();
      step();
      // lw r2, 0(r1)
      set_id(1'b1, 5'd1, 5'd2, 5'd2, 32'h200, 32'h0, 16'h0, 1'b1, 1'b1, AF_ADD, 1'b1, 1'b1, 1'b0);
      push("lw_r2", 1'b1, 1'b1, 32'h200, 32'h0, 32'h0, AF_ADD, 1'b1);
      #1;
      check_ex();
      step();
      // add r6, r2, r1 depends on the load in EX
      set_id(1'b1, 5'd2, 5'd1, 5'd6, 32'h0, 32'h300, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b1, 1'b0, 1'b1);
      #1;
      check_ex();
      chk("lu_set", 32'(lu_hazard), 32'd1);
      chk("lu_ex_mem_read", 32'(ex_mem_read), 32'd1);
      push("lu_bubble", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, AF_ADD, 1'b0);
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd2; mem_result = 32'h1;
      #1;
      check_ex();
      chk("bubble_reg_write", 32'(ex_reg_write), 32'd0);
      chk("bubble_mem_read", 32'(ex_mem_read), 32'd0);
      chk("lu_one_cycle", 32'(lu_hazard), 32'd0);
      push("lu_after_bubble", 1'b1, 1'b1, 32'h4242, 32'h300, 32'h300, AF_ADD, 1'b0);
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd2; mem_result = 32'h4242;
      // lw r9, 0(r0)
      set_id(1'b1, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 16'h0, 1'b1, 1'b1, AF_ADD, 1'b1, 1'b1, 1'b0);
      #1;
      check_ex();
      no_fwd();
      push("lw_r9", 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, AF_ADD, 1'b1);
      step();
      // subi r10 with rt=r9 not a true source -> no hazard
      set_id(1'b1, 5'd0, 5'd9, 5'd10, 32'h0, 32'h9, 16'h0005, 1'b1, 1'b1, AF_SUB, 1'b1, 1'b0, 1'b0);
      #1;
      check_ex();
      chk("lu_rt_unused", 32'(lu_hazard), 32'd0);
      push("sub_r10", 1'b1, 1'b1, 32'h0, 32'h5, 32'h9, AF_SUB, 1'b1);
      step();
      stall = 1'b1;
      set_id(1'b1, 5'd1, 5'd2, 5'd11, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, AF_OR, 1'b1, 1'b0, 1'b1);
      #1;
      check_ex();
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall_af_%0d", k), 32'(af), 32'(AF_SUB));
         chk($sformatf("stall_i_%0d", k), 32'(i), 32'd1);
         chk($sformatf("stall_rd_%0d", k), 32'(ex_rd), 32'd10);
      end
      stall = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_reg_write", 32'(ex_reg_write), 32'd0);

      // add r12, r1, r0 then reset between edges
      set_id(1'b1, 5'd1, 5'd0, 5'd12, 32'h5, 32'h0, 16'h0, 1'b0, 1'b0, AF_ADD, 1'b1, 1'b0, 1'b1);
      push("pre_reset", 1'b1, 1'b1, 32'h5, 32'h0, 32'h0, AF_ADD, 1'b0);
      step();
      #1;
      check_ex();
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(ex_valid), 32'd0);
      chk("async_rst_srca", SrcA, 32'h0);
      chk("async_rst_srcb", SrcB, 32'h0);
      chk("async_rst_lu", 32'(lu_hazard), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
